// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared FSM state type, word width and bit-counter width for the bitrev SPI master.
package bitrev_pkg;
    localparam int BITREV_BITS = 8;
    localparam int CNT_W = $clog2(BITREV_BITS + 1);
    typedef enum logic [2:0] {IDLE, PRIME, TX, RX, RESP} state_t;
    function automatic logic [BITREV_BITS-1:0] bit_rev(input logic [BITREV_BITS-1:0] d);
        for (int i = 0; i < BITREV_BITS; i++) bit_rev[i] = d[BITREV_BITS-1-i];
    endfunction
endpackage

// File: rtl/bitrev_master_if.sv
// bitrev_master_if: request/response valid-ready channels between CPU glue (master) and the SPI controller (slave).
interface bitrev_master_if;
    import bitrev_pkg::*;
    logic                   req_valid;
    logic                   req_ready;
    logic [BITREV_BITS-1:0] req_data;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [BITREV_BITS-1:0] resp_data;
    modport master(output req_valid, req_data, resp_ready, input req_ready, resp_valid, resp_data);
    modport slave(input req_valid, req_data, resp_ready, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/spi_clkgen.sv
// spi_clkgen: CLK_DIV phase counter producing sck plus single-cycle strobes on the cycles that drive sck high/low.
module spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    logic tc;
    assign tc = en && cnt == '0;
    assign rise_pulse = tc && !sck;
    assign fall_pulse = tc && sck;
    // Disabled: park low with a full phase loaded so the first rise lands CLK_DIV cycles after enable.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            cnt <= RELOAD;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= RELOAD;
            sck <= 1'b0;
        end else if (tc) begin
            cnt <= RELOAD;
            sck <= !sck;
        end else
            cnt <= cnt - 1'b1;
endmodule

// File: rtl/bitrev_master.sv
// bitrev_master: SPI master sequencing PRIME/TX/RX byte transfers to the bitrev slave.
// Optional self-check of the returned byte is built when BITREV_MASTER_CHECK_EN is defined.
module bitrev_master import bitrev_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    bitrev_master_if.slave  bus,
    output logic            busy,
    output logic            err,
    output logic            sck,
    output logic            ss,
    output logic            mosi,
    input  logic            miso
);
    state_t state, nxt;
    logic [BITREV_BITS-1:0] sh, rx, rx_nxt;
    logic [CNT_W-1:0] cnt;
    logic en, rise, fall, done;
    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clock(clock), .reset_n(reset_n), .en(en),
        .sck(sck), .rise_pulse(rise), .fall_pulse(fall)
    );
    assign done = cnt == CNT_W'(BITREV_BITS);
    assign rx_nxt = {miso, rx[BITREV_BITS-1:1]};
    assign bus.resp_data = rx;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.req_valid ? PRIME : IDLE;
            PRIME:   nxt = fall ? TX : PRIME;
            TX:      nxt = fall && done ? RX : TX;
            RX:      nxt = fall && done ? RESP : RX;
            RESP:    nxt = bus.resp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
        bus.req_ready = state == IDLE;
        bus.resp_valid = state == RESP;
        busy = state != IDLE;
        en = state == PRIME || state == TX || state == RX;
        ss = !(state == TX || state == RX);
        mosi = state == TX ? sh[BITREV_BITS-1] : 1'b1;
    end
    // Bits are counted on sck rises; sh rotates so it holds the original request again once TX ends.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            sh <= '0;
            rx <= '0;
            cnt <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                sh <= bus.req_data;
                cnt <= '0;
            end
            if (rise && (state == TX || state == RX)) cnt <= cnt + 1'b1;
            if (fall && state == TX) begin
                sh <= {sh[BITREV_BITS-2:0], sh[BITREV_BITS-1]};
                if (done) cnt <= '0;
            end
            if (fall && state == RX) rx <= rx_nxt;
        end
`ifdef BITREV_MASTER_CHECK_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) err <= 1'b0;
        else if (state == RX && fall && done && rx_nxt != bit_rev(sh)) err <= 1'b1;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bitrev_master.sv
// tb_bitrev_master: directed bench for bitrev_master at CLK_DIV 4 and 1, each wired to a behavioural bitrev slave.
module tb_bitrev_master;
`ifdef BITREV_MASTER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;
    bitrev_master_if b4();
    bitrev_master_if b1();
    logic busy4, err4, sck4, ss4, mosi4, miso4 = 1'b0;
    logic busy1, err1, sck1, ss1, mosi1, miso1 = 1'b0;
    logic force0 = 1'b0;
    logic [7:0] s4 = '0, s1 = '0;
    int c4 = 0, c1 = 0;
    int total = 0, passed = 0, lat = 0, acc_n = 0;
    logic first_ss = 1'b0;
    bitrev_master #(.CLK_DIV(4)) u4 (
        .clock(clock), .reset_n(reset_n), .bus(b4), .busy(busy4), .err(err4),
        .sck(sck4), .ss(ss4), .mosi(mosi4), .miso(miso4)
    );
    bitrev_master #(.CLK_DIV(1)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(b1), .busy(busy1), .err(err1),
        .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
    );
    // Slave: reset on sck rise with ss high, shift in 8 bits, then replay them MSB-first on later rises.
    always @(posedge sck4)
        if (ss4) begin c4 <= 0; s4 <= '0; end
        else if (c4 < 8) begin s4 <= {s4[6:0], mosi4}; c4 <= c4 + 1; end
        else begin miso4 <= force0 ? 1'b0 : s4[7]; s4 <= {s4[6:0], 1'b0}; end
    always @(posedge sck1)
        if (ss1) begin c1 <= 0; s1 <= '0; end
        else if (c1 < 8) begin s1 <= {s1[6:0], mosi1}; c1 <= c1 + 1; end
        else begin miso1 <= s1[7]; s1 <= {s1[6:0], 1'b0}; end

    task automatic req4(input logic [7:0] d);
        logic acc, seen;
        acc = 1'b0; seen = 1'b0; acc_n = 0; first_ss = 1'b0;
        b4.req_valid = 1'b1; b4.req_data = d;
        while (!acc && acc_n < 50) begin acc = b4.req_ready; @(negedge clock); acc_n++; end
        b4.req_valid = 1'b0;
        lat = 1;
        while (!b4.resp_valid && lat < 1000) begin
            if (sck4 && !seen) begin seen = 1'b1; first_ss = ss4; end
            @(negedge clock); lat++;
        end
    endtask

    task automatic ack4();
        b4.resp_ready = 1'b1;
        @(negedge clock);
        b4.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        total++; if ({sck4, ss4, mosi4, busy4, err4} !== 5'b01100) $display("FAIL reset_pins4 got %b exp 01100", {sck4, ss4, mosi4, busy4, err4}); else passed++;
        total++; if ({b4.resp_valid, b4.resp_data} !== 9'h0) $display("FAIL reset_resp4 got %h exp 000", {b4.resp_valid, b4.resp_data}); else passed++;
        total++; if ({sck1, ss1, mosi1, busy1} !== 4'b0110) $display("FAIL reset_pins1 got %b exp 0110", {sck1, ss1, mosi1, busy1}); else passed++;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (b4.req_ready !== 1'b1 || b1.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b%b exp 11", b4.req_ready, b1.req_ready); else passed++;
    endtask

    task automatic test_single();
        req4(8'h01);
        total++; if (b4.resp_data !== 8'h80) $display("FAIL single_data got %h exp 80", b4.resp_data); else passed++;
        total++; if (lat !== 137) $display("FAIL single_latency got %0d exp 137", lat); else passed++;
        total++; if (first_ss !== 1'b1) $display("FAIL single_prime_ss got %b exp 1", first_ss); else passed++;
        total++; if (err4 !== 1'b0) $display("FAIL single_err got %b exp 0", err4); else passed++;
        ack4();
        total++; if (b4.req_ready !== 1'b1 || b4.resp_valid !== 1'b0) $display("FAIL single_idle got %b%b exp 10", b4.req_ready, b4.resp_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        b4.resp_ready = 1'b1;
        req4(8'hA5);
        total++; if (b4.resp_data !== 8'hA5) $display("FAIL b2b_first got %h exp a5", b4.resp_data); else passed++;
        req4(8'h3C);
        total++; if (acc_n !== 2) $display("FAIL b2b_accept got %0d cycles exp 2", acc_n); else passed++;
        total++; if (b4.resp_data !== 8'h3C) $display("FAIL b2b_second got %h exp 3c", b4.resp_data); else passed++;
        total++; if (lat !== 137) $display("FAIL b2b_latency got %0d exp 137", lat); else passed++;
        @(negedge clock);
        b4.resp_ready = 1'b0;
    endtask

    task automatic test_stall();
        req4(8'h12);
        for (int i = 0; i < 50; i++) begin
            total++;
            if (b4.resp_data !== 8'h48 || ss4 !== 1'b1 || sck4 !== 1'b0 || mosi4 !== 1'b1 || b4.req_ready !== 1'b0 || b4.resp_valid !== 1'b1)
                $display("FAIL stall_hold cycle %0d got data %h ss %b sck %b mosi %b rdy %b vld %b exp 48 1 0 1 0 1", i, b4.resp_data, ss4, sck4, mosi4, b4.req_ready, b4.resp_valid);
            else passed++;
            @(negedge clock);
        end
        ack4();
        total++; if (busy4 !== 1'b0) $display("FAIL stall_release got busy %b exp 0", busy4); else passed++;
    endtask

    task automatic test_reset_mid_tx();
        b4.req_valid = 1'b1; b4.req_data = 8'h77;
        @(negedge clock);
        b4.req_valid = 1'b0;
        repeat (29) @(negedge clock);
        total++; if (ss4 !== 1'b0 || busy4 !== 1'b1) $display("FAIL midtx_state got ss %b busy %b exp 0 1", ss4, busy4); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if ({sck4, ss4, mosi4, busy4, b4.resp_valid, b4.req_ready} !== 6'b011001) $display("FAIL midtx_reset got %b exp 011001", {sck4, ss4, mosi4, busy4, b4.resp_valid, b4.req_ready}); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        req4(8'h0F);
        total++; if (b4.resp_data !== 8'hF0) $display("FAIL midtx_recover got %h exp f0", b4.resp_data); else passed++;
        ack4();
    endtask

    task automatic test_clkdiv1();
        logic [7:0] vin [2];
        logic [7:0] vexp [2];
        int l;
        vin[0] = 8'hFF; vexp[0] = 8'hFF;
        vin[1] = 8'h01; vexp[1] = 8'h80;
        for (int k = 0; k < 2; k++) begin
            b1.req_valid = 1'b1; b1.req_data = vin[k];
            @(negedge clock);
            b1.req_valid = 1'b0;
            l = 1;
            while (!b1.resp_valid && l < 200) begin @(negedge clock); l++; end
            total++; if (b1.resp_data !== vexp[k]) $display("FAIL div1_data got %h exp %h", b1.resp_data, vexp[k]); else passed++;
            total++; if (l !== 35) $display("FAIL div1_latency got %0d exp 35", l); else passed++;
            b1.resp_ready = 1'b1;
            @(negedge clock);
            b1.resp_ready = 1'b0;
        end
    endtask

    task automatic test_check();
        force0 = 1'b1;
        req4(8'h81);
        force0 = 1'b0;
        total++; if (b4.resp_data !== 8'h00) $display("FAIL check_forced_data got %h exp 00", b4.resp_data); else passed++;
        total++; if (err4 !== EXP_ERR) $display("FAIL check_err_set got %b exp %b", err4, EXP_ERR); else passed++;
        ack4();
        req4(8'h3C);
        total++; if (b4.resp_data !== 8'h3C) $display("FAIL check_after_data got %h exp 3c", b4.resp_data); else passed++;
        total++; if (err4 !== EXP_ERR) $display("FAIL check_err_sticky got %b exp %b", err4, EXP_ERR); else passed++;
        ack4();
    endtask

    initial begin
        b4.req_valid = 1'b0; b4.req_data = '0; b4.resp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_data = '0; b1.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid_tx();
        test_clkdiv1();
        test_check();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
